// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit peripheral: register map, STATUS layout,
// transmitter state encoding and the baud-divisor clamp.
package uart_pkg;

  localparam logic [1:0] RegTxData  = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegBaudDiv = 2'd2;
  localparam logic [1:0] RegCtrl    = 2'd3;

  localparam int unsigned StatusBusy   = 0;
  localparam int unsigned StatusFull   = 1;
  localparam int unsigned StatusEmpty  = 2;
  localparam int unsigned StatusOvf    = 3;
  localparam int unsigned StatusCntLsb = 4;
  localparam int unsigned StatusCntW   = 4;

  localparam int unsigned DivW   = 16;
  localparam logic [DivW-1:0] DivMin = 16'd2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Divisors below two cannot produce a usable bit period.
  function automatic logic [DivW-1:0] eff_div(input logic [DivW-1:0] div);
    return (div < DivMin) ? DivMin : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth; a push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers are exactly log2(Depth) wide, so increments wrap modulo Depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV/CTRL registers in front of
// a transmit FIFO and a start/data/stop serialiser with a per-bit down-counter.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int unsigned     FIFO_DEPTH = 8,
  parameter logic [DivW-1:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  memWrite,
  input  logic [10:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd
);

  tx_state_e         state_q, state_d;
  logic [DivW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [DivW-1:0]   baud_q, baud_d;
  logic              ctrl_q, ctrl_d;
  logic              ovf_q, ovf_d;

  logic [1:0]        reg_sel;
  logic              wr_en, wr_tx, wr_status, wr_baud, wr_ctrl;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [DivW-1:0]   div_eff;
  logic              bit_done, start_ok;
  logic [31:0]       status_word;
  logic              unused_bits;

  assign reg_sel   = addr[3:2];
  assign wr_en     = en & memWrite[0];
  assign wr_tx     = wr_en & (reg_sel == RegTxData);
  assign wr_status = wr_en & (reg_sel == RegStatus);
  assign wr_baud   = wr_en & (reg_sel == RegBaudDiv);
  assign wr_ctrl   = wr_en & (reg_sel == RegCtrl);

  assign unused_bits = ^{addr[10:4], addr[1:0], memWrite[3:2], wdata[31:16]};

  sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .pop   (fifo_pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register file; overflow only latches when the write is genuinely dropped.
  always_comb begin
    baud_d = baud_q;
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    if (wr_baud) begin
      baud_d[7:0] = wdata[7:0];
      if (memWrite[1]) baud_d[15:8] = wdata[15:8];
    end
    if (wr_ctrl) ctrl_d = wdata[0];
    if (wr_tx && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (wr_status && wdata[StatusOvf]) begin
      ovf_d = 1'b0;
    end
  end

  // The divisor is sampled only when the bit counter reloads, so writes take
  // effect at the next bit boundary.
  assign div_eff  = eff_div(baud_q);
  assign bit_done = (cnt_q == '0);
  assign start_ok = ctrl_q & ~fifo_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          cnt_d    = div_eff - 16'd1;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          bit_idx_d = 3'd0;
          cnt_d     = div_eff - 16'd1;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = div_eff - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (start_ok) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            cnt_d    = div_eff - 16'd1;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      baud_q    <= DIV_RESET;
      ctrl_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      baud_q    <= baud_d;
      ctrl_q    <= ctrl_d;
      ovf_q     <= ovf_d;
    end
  end

  // txd decodes straight from state so reset forces the line high immediately.
  always_comb begin
    unique case (state_q)
      StStart: txd = 1'b0;
      StData:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  always_comb begin
    status_word = '0;
    status_word[StatusBusy]  = (state_q != StIdle);
    status_word[StatusFull]  = fifo_full;
    status_word[StatusEmpty] = fifo_empty;
    status_word[StatusOvf]   = ovf_q;
    status_word[StatusCntLsb +: StatusCntW] = StatusCntW'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (en) begin
      unique case (reg_sel)
        RegStatus:  rdata = status_word;
        RegBaudDiv: rdata = {16'd0, baud_q};
        RegCtrl:    rdata = {31'd0, ctrl_q};
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: random bytes and divisors checked cycle by cycle against
// an expected line waveform built from the 8N1 frame rules.
module tb_uart_tx_periph;

  localparam logic [1:0] RTx = 2'd0, RStatus = 2'd1, RBaud = 2'd2, RCtrl = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  memWrite;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        txd;

  int checks = 0;
  int errors = 0;

  bit          exp_line[$];
  int          pend_at = -1;
  logic [1:0]  pend_reg;
  logic [31:0] pend_data;

  always #5 clk = ~clk;

  uart_tx_periph dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .memWrite (memWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .txd      (txd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic logic [31:0] exp_status(input bit busy, input int cnt, input bit ovf);
    logic [31:0] s;
    s = '0;
    s[0] = busy;
    s[1] = (cnt == 8);
    s[2] = (cnt == 0);
    s[3] = ovf;
    s[7:4] = 4'(cnt);
    return s;
  endfunction

  // Frame: start 0, eight data bits LSB first, stop 1.
  task automatic add_frame(input logic [7:0] b, input int d_first, input int d_rest);
    bit lvl;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) lvl = 1'b0;
      else if (k == 9) lvl = 1'b1;
      else lvl = b[k-1];
      for (int n = 0; n < ((k == 0) ? d_first : d_rest); n++) exp_line.push_back(lvl);
    end
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] be);
    en = 1'b1;
    memWrite = be;
    addr = {7'($urandom), r, 2'b00};
    wdata = d;
    @(negedge clk);
    en = 1'b0;
    memWrite = 4'b0000;
    wdata = $urandom;
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
    en = 1'b1;
    memWrite = 4'b0000;
    addr = {7'($urandom), r, 2'b00};
    #1;
    d = rdata;
    en = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (txd !== 1'b0 && n < 32) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_start"}, 32'(txd), 32'd0);
  endtask

  task automatic check_stream(input string tag);
    for (int i = 0; i < exp_line.size(); i++) begin
      check_eq(tag, 32'(txd), 32'(exp_line[i]));
      if (pend_at >= 0 && i == pend_at) begin
        en = 1'b1;
        memWrite = 4'b0011;
        addr = {7'($urandom), pend_reg, 2'b00};
        wdata = pend_data;
      end else if (pend_at >= 0 && i == pend_at + 1) begin
        en = 1'b0;
        memWrite = 4'b0000;
      end
      @(negedge clk);
    end
    en = 1'b0;
    memWrite = 4'b0000;
    pend_at = -1;
    exp_line.delete();
  endtask

  task automatic run_burst(input int div_val, input int nbytes, input string tag);
    logic [7:0]  b;
    logic [31:0] st;
    bus_write(RCtrl, 32'd0, 4'b0001);
    bus_write(RBaud, 32'(div_val), 4'b0011);
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      bus_write(RTx, {24'($urandom), b}, 4'b0001);
      add_frame(b, eff(div_val), eff(div_val));
    end
    bus_read(RStatus, st);
    check_eq({tag, "_queued"}, st, exp_status(1'b0, nbytes, 1'b0));
    bus_write(RCtrl, 32'd1, 4'b0001);
    wait_start(tag);
    check_stream(tag);
    check_eq({tag, "_idle_txd"}, 32'(txd), 32'd1);
    bus_read(RStatus, st);
    check_eq({tag, "_done_status"}, st, exp_status(1'b0, 0, 1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] st;
    logic [7:0]  b, b2;
    logic [7:0]  q[$];
    bit          ovf;

    en = 1'b0; memWrite = 4'b0000; addr = '0; wdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("txd_in_reset", 32'(txd), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Reset values and read decode
    bus_read(RStatus, st);  check_eq("rst_status", st, 32'h4);
    bus_read(RBaud, st);    check_eq("rst_baud", st, 32'd434);
    bus_read(RCtrl, st);    check_eq("rst_ctrl", st, 32'd0);
    bus_read(RTx, st);      check_eq("txdata_read", st, 32'd0);
    en = 1'b0; addr = {7'd0, RBaud, 2'b00}; #1;
    check_eq("rdata_no_en", rdata, 32'd0);

    // Byte enables on BAUDDIV
    bus_write(RBaud, 32'h0000ABCD, 4'b0010);
    bus_read(RBaud, st);    check_eq("baud_no_be0", st, 32'd434);
    bus_write(RBaud, 32'h0000ABCD, 4'b0001);
    bus_read(RBaud, st);    check_eq("baud_low_only", st, 32'h01CD);
    bus_write(RBaud, 32'hFFFF0004, 4'b1111);
    bus_read(RBaud, st);    check_eq("baud_full", st, 32'd4);

    // Single byte A5 at divisor 4
    bus_write(RTx, {24'($urandom), 8'hA5}, 4'b0001);
    bus_write(RCtrl, 32'd1, 4'b0001);
    add_frame(8'hA5, 4, 4);
    wait_start("single");
    bus_read(RStatus, st);  check_eq("single_busy", st, exp_status(1'b1, 0, 1'b0));
    check_stream("single");
    bus_read(RStatus, st);  check_eq("single_done", st, exp_status(1'b0, 0, 1'b0));

    // Overflow, W1C, then pop+push while full
    bus_write(RCtrl, 32'd0, 4'b0001);
    bus_write(RBaud, 32'd2, 4'b0011);
    ovf = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      bus_write(RTx, {24'($urandom), b}, 4'b0001);
      if (q.size() < 8) q.push_back(b);
      else ovf = 1'b1;
    end
    bus_read(RStatus, st);  check_eq("ovf_set", st, exp_status(1'b0, q.size(), ovf));
    bus_write(RStatus, 32'hFFFF_FFF7, 4'b1111);
    bus_read(RStatus, st);  check_eq("ovf_w0_keeps", st, exp_status(1'b0, 8, 1'b1));
    bus_write(RStatus, 32'h0000_0008, 4'b0001);
    bus_read(RStatus, st);  check_eq("ovf_w1c", st, exp_status(1'b0, 8, 1'b0));
    bus_write(RCtrl, 32'd1, 4'b0001);
    b = 8'($urandom);
    bus_write(RTx, {24'($urandom), b}, 4'b0001);
    q.push_back(b);
    bus_read(RStatus, st);  check_eq("full_pop_push", st, exp_status(1'b1, 8, 1'b0));
    foreach (q[i]) add_frame(q[i], 2, 2);
    q.delete();
    wait_start("drain");
    check_stream("drain");
    bus_read(RStatus, st);  check_eq("drain_done", st, exp_status(1'b0, 0, 1'b0));

    // Back-to-back three bytes at divisor 2
    run_burst(2, 3, "b2b");

    // Divisor change mid start bit
    bus_write(RCtrl, 32'd0, 4'b0001);
    bus_write(RBaud, 32'd4, 4'b0011);
    b = 8'($urandom);
    bus_write(RTx, {24'd0, b}, 4'b0001);
    bus_write(RCtrl, 32'd1, 4'b0001);
    add_frame(b, 4, 8);
    pend_at = 1; pend_reg = RBaud; pend_data = 32'd8;
    wait_start("baudchg");
    check_stream("baudchg");
    bus_read(RBaud, st);    check_eq("baudchg_reg", st, 32'd8);

    // Divisor 0 clamps to 2; disabling mid-frame finishes the frame and keeps the queue
    bus_write(RCtrl, 32'd0, 4'b0001);
    bus_write(RBaud, 32'd0, 4'b0011);
    b = 8'($urandom);
    b2 = 8'($urandom);
    bus_write(RTx, {24'd0, b}, 4'b0001);
    bus_write(RTx, {24'd0, b2}, 4'b0001);
    bus_write(RCtrl, 32'd1, 4'b0001);
    add_frame(b, 2, 2);
    for (int i = 0; i < 20; i++) exp_line.push_back(1'b1);
    pend_at = 5; pend_reg = RCtrl; pend_data = 32'd0;
    wait_start("disable");
    check_stream("disable");
    bus_read(RStatus, st);  check_eq("disable_kept", st, exp_status(1'b0, 1, 1'b0));
    bus_write(RCtrl, 32'd1, 4'b0001);
    add_frame(b2, 2, 2);
    wait_start("resume");
    check_stream("resume");
    bus_read(RStatus, st);  check_eq("resume_done", st, exp_status(1'b0, 0, 1'b0));

    // Randomised bursts
    for (int it = 0; it < 5; it++) begin
      run_burst(int'($urandom_range(0, 5)), int'($urandom_range(1, 4)), "rand");
    end

    // Reset in the middle of a frame of zeros
    bus_write(RCtrl, 32'd0, 4'b0001);
    bus_write(RBaud, 32'd4, 4'b0011);
    bus_write(RTx, 32'd0, 4'b0001);
    bus_write(RCtrl, 32'd1, 4'b0001);
    add_frame(8'h00, 4, 4);
    while (exp_line.size() > 12) void'(exp_line.pop_back());
    wait_start("prerst");
    check_stream("prerst");
    rst = 1'b0;
    #1;
    check_eq("rst_txd_now", 32'(txd), 32'd1);
    bus_read(RStatus, st);  check_eq("rst_mid_status", st, 32'h4);
    bus_read(RBaud, st);    check_eq("rst_mid_baud", st, 32'd434);
    bus_read(RCtrl, st);    check_eq("rst_mid_ctrl", st, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_txd", 32'(txd), 32'd1);
    end
    bus_read(RStatus, st);  check_eq("post_rst_status", st, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
